pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It generates the write-enable, flush and bubble controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, kills wrong-path instructions on taken branches, and freezes the pipe while a multi-cycle data-memory access is outstanding. A watchdog with a sticky error flag bounds each memory wait, and a saturating counter records stall cycles.

## Interface
Parameters:
- MEM_TIMEOUT, default 15: maximum wait count tolerated in MEM_WAIT before the block enters ERROR.
- STALL_W, default 16: width of StallCount.

Ports:
- Clk  in  1  clock; all state updates on its rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads rt as a source.
- EX_MemRead  in  1  the instruction in EX is a load.
- EX_RegDst  in  5  destination register of the EX instruction.
- EX_BranchTaken  in  1  the branch/jump in EX resolved as taken.
- MEM_Req  in  1  the MEM-stage instruction accesses data memory.
- MEM_Ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID load enable.
- IF_ID_Flush  out  1  IF/ID load NOP.
- ID_EX_Write  out  1  ID/EX load enable.
- ID_EX_Flush  out  1  ID/EX load bubble (all control fields zero).
- EX_MEM_Write  out  1  EX/MEM load enable.
- MEM_WB_Bubble  out  1  MEM/WB captures zero control (RegWrite=0).
- MemError  out  1  sticky flag: memory watchdog expired.
- StallCount  out  STALL_W  saturating count of cycles with PCWrite=0.

## Operation
- freeze = MEM_Req & ~MEM_Ready.
- hazard = EX_MemRead & (EX_RegDst != 0) & ((EX_RegDst == ID_Rs) | (ID_UsesRt & EX_RegDst == ID_Rt)).
- States: RUN, MEM_WAIT, ERROR.
- Outputs are combinational from the state and inputs, evaluated in the following priority order:
  1. State ERROR or freeze: PCWrite, IF_ID_Write, ID_EX_Write and EX_MEM_Write all 0. MEM_WB_Bubble=1. Both flushes 0.
  2. EX_BranchTaken: all write enables 1. IF_ID_Flush=1 and ID_EX_Flush=1, killing two wrong-path instructions. MEM_WB_Bubble=0.
  3. hazard: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. ID_EX_Write and EX_MEM_Write 1. IF_ID_Flush=0. MEM_WB_Bubble=0.
  4. Otherwise: all write enables 1, flushes 0, MEM_WB_Bubble=0.
- A branch that arrives during a freeze is not lost. EX is held, so EX_BranchTaken remains asserted and takes effect in the first unfrozen cycle.
- FSM transitions (WaitCnt is an internal counter, wide enough to hold MEM_TIMEOUT):
  - RUN: if freeze, go to MEM_WAIT and set WaitCnt←1. Otherwise stay in RUN.
  - MEM_WAIT: if !freeze, go to RUN and set WaitCnt←0. Otherwise, if WaitCnt==MEM_TIMEOUT, go to ERROR and set MemError←1. Otherwise WaitCnt←WaitCnt+1.
  - ERROR: absorbing until reset. MemError stays 1 and the pipe stays frozen whatever the inputs are.
- StallCount increments by 1 on every edge where PCWrite==0 and Rst_n is high. It saturates at 2^STALL_W−1 and never wraps.
- Reset (Rst_n low):
  - Asynchronous: state←RUN, WaitCnt←0, MemError←0, StallCount←0.
  - While Rst_n is low the outputs are forced regardless of inputs: all write enables 0, flushes 0, MEM_WB_Bubble=1.
  - Reset asserted mid-wait or in ERROR returns the block to RUN immediately.

## Timing
- Control outputs have zero-cycle latency: combinational from inputs in the same cycle.
- MemError, StallCount and the state are registered and change only at the rising edge of Clk, except on asynchronous reset.
- Load-use hazard costs exactly 1 stall cycle. On the next edge the load advances to MEM, hazard drops, and the pipe resumes.
- Taken branch costs 2 flushed slots and no stall cycle.
- Memory wait: the pipe is frozen for every cycle in which freeze is high. Freeze held for MEM_TIMEOUT+1 consecutive cycles causes MemError=1 starting in the next cycle.
- MEM_Ready high in the same cycle as MEM_Req means no freeze and no state change.
- freeze and hazard in the same cycle: freeze wins. The hazard is re-evaluated after the release.

## Test plan
- Reset release, no hazards, 10 cycles → all write enables 1, flushes 0, StallCount=0.
- Load r5 in EX, ID_Rs=5 → cycle 1: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. Cycle 2: all normal. StallCount=1.
- Load r0 in EX, ID_Rs=0 → no stall. Load r7 with ID_Rt=7 and ID_UsesRt=0 → no stall.
- EX_BranchTaken for 1 cycle → IF_ID_Flush=ID_EX_Flush=1, PCWrite=1, same cycle.
- MEM_TIMEOUT=4, MEM_Req=1:
  - MEM_Ready rises on the 5th cycle → 4 frozen cycles, then RUN, MemError=0, StallCount=4.
  - Ready never asserted → MemError=1 from the 6th cycle, pipe stays frozen. Rst_n low then clears everything.
- Branch asserted during a 3-cycle freeze → flushes occur in the first cycle after MEM_Ready, not before. StallCount saturates at 0xFFFF under a forced long stall with STALL_W=16.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use stalls, taken-branch kills,
// memory-wait freeze with a watchdog, sticky error flag and saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int STALL_W     = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [4:0]         ID_Rs,
  input  logic [4:0]         ID_Rt,
  input  logic               ID_UsesRt,
  input  logic               EX_MemRead,
  input  logic [4:0]         EX_RegDst,
  input  logic               EX_BranchTaken,
  input  logic               MEM_Req,
  input  logic               MEM_Ready,
  output logic               PCWrite,
  output logic               IF_ID_Write,
  output logic               IF_ID_Flush,
  output logic               ID_EX_Write,
  output logic               ID_EX_Flush,
  output logic               EX_MEM_Write,
  output logic               MEM_WB_Bubble,
  output logic               MemError,
  output logic [STALL_W-1:0] StallCount
);

  localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0]     TMO  = WCW'(MEM_TIMEOUT);
  localparam logic [STALL_W-1:0] SMAX = '1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           mem_err_nxt;
  logic           freeze, hazard;

  assign freeze = MEM_Req & ~MEM_Ready;
  assign hazard = EX_MemRead & (EX_RegDst != 5'd0) &
                  ((EX_RegDst == ID_Rs) | (ID_UsesRt & (EX_RegDst == ID_Rt)));

  // Defaults describe the frozen pipe, which is also what reset must present.
  always_comb begin
    PCWrite       = 1'b0;
    IF_ID_Write   = 1'b0;
    IF_ID_Flush   = 1'b0;
    ID_EX_Write   = 1'b0;
    ID_EX_Flush   = 1'b0;
    EX_MEM_Write  = 1'b0;
    MEM_WB_Bubble = 1'b1;
    if (Rst_n && state != ERROR && !freeze) begin
      MEM_WB_Bubble = 1'b0;
      ID_EX_Write   = 1'b1;
      EX_MEM_Write  = 1'b1;
      if (EX_BranchTaken) begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end else if (hazard) begin
        ID_EX_Flush = 1'b1;
      end else begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = MemError;
    unique case (state)
      RUN: begin
        if (freeze) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (!freeze) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TMO) begin
          state_nxt   = ERROR;
          mem_err_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WCW'(1);
        end
      end
      ERROR:   mem_err_nxt = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= RUN;
      wait_cnt   <= '0;
      MemError   <= 1'b0;
      StallCount <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      MemError <= mem_err_nxt;
      if (!PCWrite && StallCount != SMAX)
        StallCount <= StallCount + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl: a behavioural model pushes
// expected controls/counters per cycle, a monitor pops and compares at negedge.
module tb_pipeline_hazard_ctrl;

  localparam int T   = 4;
  localparam int SW  = 12;
  localparam int MAX = (1 << SW) - 1;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic [4:0]    ID_Rs = '0, ID_Rt = '0, EX_RegDst = '0;
  logic          ID_UsesRt = 1'b0, EX_MemRead = 1'b0, EX_BranchTaken = 1'b0;
  logic          MEM_Req = 1'b0, MEM_Ready = 1'b0;
  logic          PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
  logic          EX_MEM_Write, MEM_WB_Bubble, MemError;
  logic [SW-1:0] StallCount;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .STALL_W(SW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_RegDst(EX_RegDst), .EX_BranchTaken(EX_BranchTaken),
    .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Write(EX_MEM_Write), .MEM_WB_Bubble(MEM_WB_Bubble), .MemError(MemError),
    .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  // ctl order: PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble
  typedef struct packed {
    logic [6:0]    ctl;
    logic          err;
    logic [SW-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc_no = 0;

  // Reference model state: consecutive frozen cycles, error flag, stall total.
  int   m_frz_run = 0, m_cnt = 0;
  bit   m_err = 0, m_pcw = 0, m_frz = 0;

  task automatic tick(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                      input bit ut, input bit mr, input logic [4:0] rd,
                      input bit bt, input bit mq, input bit my);
    exp_t e;
    bit hz;
    @(posedge Clk);
    if (Rst_n) begin
      if (!m_pcw && m_cnt < MAX) m_cnt++;
      if (!m_err) begin
        if (m_frz) begin
          m_frz_run++;
          if (m_frz_run > T) m_err = 1;
        end else m_frz_run = 0;
      end
    end
    #1;
    Rst_n = rst; ID_Rs = rs; ID_Rt = rt; ID_UsesRt = ut; EX_MemRead = mr;
    EX_RegDst = rd; EX_BranchTaken = bt; MEM_Req = mq; MEM_Ready = my;
    if (!rst) begin
      m_err = 0; m_frz_run = 0; m_cnt = 0;
    end
    m_frz = mq && !my;
    hz = mr && rd != 0 && (rd == rs || (ut && rd == rt));
    if (!rst || m_err || m_frz) e.ctl = 7'b0000001;
    else if (bt)                e.ctl = 7'b1111110;
    else if (hz)                e.ctl = 7'b0001110;
    else                        e.ctl = 7'b1101010;
    e.err = m_err;
    e.cnt = SW'(m_cnt);
    m_pcw = e.ctl[6];
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge Clk);
      cyc_no++;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        act = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble};
        n_chk += 3;
        if (act !== e.ctl) begin
          n_fail++;
          $display("FAIL ctl cyc=%0d got=%b exp=%b", cyc_no, act, e.ctl);
        end
        if (MemError !== e.err) begin
          n_fail++;
          $display("FAIL MemError cyc=%0d got=%b exp=%b", cyc_no, MemError, e.err);
        end
        if (StallCount !== e.cnt) begin
          n_fail++;
          $display("FAIL StallCount cyc=%0d got=%0d exp=%0d", cyc_no, StallCount, e.cnt);
        end
      end
    end
  end

  initial begin
    int mode;
    bit rst, mq, my;
    // Reset state, then quiet pipe
    for (int i = 0; i < 3; i++) tick(0, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0);
    idle(10);
    // Load-use on rs, then r0 and unused-rt loads (no stall)
    tick(1, 5'd5, 5'd9, 0, 1, 5'd5, 0, 0, 0);
    idle(2);
    tick(1, 5'd0, 5'd3, 1, 1, 5'd0, 0, 0, 0);
    tick(1, 5'd4, 5'd7, 0, 1, 5'd7, 0, 0, 0);
    tick(1, 5'd4, 5'd7, 1, 1, 5'd7, 0, 0, 0);
    idle(1);
    // Taken branch alone, and branch beating a hazard
    tick(1, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 0);
    tick(1, 5'd6, 5'd2, 1, 1, 5'd6, 1, 0, 0);
    // Ready in same cycle as request, then 4-cycle freeze released on the 5th
    tick(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 1);
    for (int i = 0; i < 4; i++) tick(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0);
    tick(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 1);
    idle(3);
    // Branch held across a 3-cycle freeze with a hazard also present
    for (int i = 0; i < 3; i++) tick(1, 5'd3, 5'd2, 1, 1, 5'd3, 1, 1, 0);
    tick(1, 5'd3, 5'd2, 1, 1, 5'd3, 1, 1, 1);
    idle(2);
    // Watchdog: never ready, error absorbing even with inputs quiet
    for (int i = 0; i < T + 3; i++) tick(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0);
    idle(4);
    tick(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 0);
    idle(4);
    // Random traffic with bursty memory latency and sporadic resets
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) mode = $urandom_range(0, 2);
      rst = ($urandom_range(0, 249) != 0);
      mq  = ($urandom_range(0, 3) == 0) || (mode == 2);
      my  = (mode == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
      tick(rst, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0), mq, my);
    end
    // Long error-induced stall to reach counter saturation
    tick(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0);
    for (int i = 0; i < MAX + 40; i++) tick(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0);
    // Drain scoreboard with a bound
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge Clk);
    @(posedge Clk);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
